// File: rtl/rx_packet_ctrl.sv
// Purpose : frames the byte receiver's stream (SYNC, LEN, payload, CHK) into checksummed packets,
//           store-and-forward: a payload is released only after its checksum passes.
// Latency : first out_valid one cycle after the CHK byte strobe, then one byte per cycle.
// Backpressure: out_data/out_valid/out_last hold while out_ready is low; bytes arriving while
//           draining are dropped and flagged on overrun.
// Ports   : clk/rst (async active-low); rx_word/rx_ready from the receiver (0->1 on rx_ready
//           = new byte); out_data/out_valid/out_ready/out_last consumer stream; pkt_ok/pkt_err/
//           overrun one-cycle status pulses; busy = not idle.
// Option  : define RXP_TIMEOUT_EN to abort a packet after TIMEOUT_CYC cycles without a byte.
module rx_packet_ctrl #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_word,
    input  logic       rx_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       overrun,
    output logic       busy
);
    localparam int         PW        = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

    state_t     state;
    logic       rx_ready_q;
    logic       byte_stb;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [7:0] rd_next;
    logic [7:0] chk_sum;
    logic       timeout;
    logic [7:0] buf_mem [MAX_LEN];

    // rx_ready_q resets high so a receiver already idling at 1 gives no strobe after reset
    assign byte_stb = rx_ready & ~rx_ready_q;
    assign chk_sum  = sum + rx_word;
    assign rd_next  = rd_ptr + 8'd1;

`ifdef RXP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_active;

    assign tmo_active = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    // Cycle k after the last strobe sees tmo_cnt == k-1, so this fires exactly TIMEOUT_CYC
    // cycles after the last byte.
    assign timeout    = tmo_active && !byte_stb && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (!tmo_active || byte_stb || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    // TIMEOUT_CYC is always positive, so without the counter this never fires.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // Payload buffer: contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && byte_stb) begin
            buf_mem[wr_ptr[PW-1:0]] <= rx_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rx_ready_q <= 1'b1;
            len        <= '0;
            sum        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            overrun    <= 1'b0;
            if (timeout) begin
                pkt_err <= 1'b1;
                state   <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_stb && rx_word == SYNC_BYTE) begin
                            state <= S_LEN;
                            busy  <= 1'b1;
                        end
                    end
                    S_LEN: begin
                        if (byte_stb) begin
                            len    <= rx_word;
                            sum    <= rx_word;
                            wr_ptr <= '0;
                            if (rx_word == 8'd0) begin
                                state <= S_CHK;
                            end else if (rx_word > MAX_LEN_B) begin
                                pkt_err <= 1'b1;
                                state   <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        // SYNC_BYTE values here are plain data; no re-hunting mid-packet
                        if (byte_stb) begin
                            sum    <= sum + rx_word;
                            wr_ptr <= wr_ptr + 8'd1;
                            if (wr_ptr + 8'd1 == len) begin
                                state <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (byte_stb) begin
                            if (chk_sum == 8'd0) begin
                                pkt_ok <= 1'b1;
                                if (len == 8'd0) begin
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end else begin
                                    // Present the first byte straight away
                                    state     <= S_DRAIN;
                                    rd_ptr    <= '0;
                                    out_valid <= 1'b1;
                                    out_data  <= buf_mem[0];
                                    out_last  <= (len == 8'd1);
                                end
                            end else begin
                                pkt_err <= 1'b1;
                                state   <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (byte_stb) begin
                            overrun <= 1'b1;
                        end
                        if (out_valid && out_ready) begin
                            if (out_last) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end else begin
                                rd_ptr   <= rd_next;
                                out_data <= buf_mem[rd_next[PW-1:0]];
                                out_last <= (rd_next == len - 8'd1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
module tb_rx_packet_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXL = 16;

    logic       clk;
    logic       rst;
    logic [7:0] rx_word;
    logic       rx_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic       overrun;
    logic       busy;

    rx_packet_ctrl dut (
        .clk(clk), .rst(rst), .rx_word(rx_word), .rx_ready(rx_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
        .overrun(overrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Consumer: 0 = stall, 1 = always ready, 2 = random. Changes only just after posedge.
    int rdy_mode = 1;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: collects handshakes and pulses, checks hold-under-stall and ok/err exclusivity.
    int         mon_ok   = 0;
    int         mon_err  = 0;
    int         mon_ovr  = 0;
    int         mon_both = 0;
    int         mon_stab = 0;
    logic [8:0] got_q [$];
    logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (pkt_ok)  mon_ok++;
            if (pkt_err) mon_err++;
            if (overrun) mon_ovr++;
            if (pkt_ok && pkt_err) mon_both++;
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (pv && !pr && (!out_valid || out_data != pd || out_last != pl)) mon_stab++;
        end
        pv = out_valid && rst;
        pr = out_ready;
        pd = out_data;
        pl = out_last;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    logic [7:0] stream [$];

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_word  = b;
        rx_ready = 1'b1;
        stream.push_back(b);
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Packet-level reference: parse a byte stream by the framing rules.
    int         m_ok, m_err;
    logic [8:0] exp_q [$];
    task automatic model_stream();
        int i = 0;
        int ln, total;
        m_ok = 0;
        m_err = 0;
        exp_q.delete();
        while (i < stream.size()) begin
            if (stream[i] != SYNC) begin
                i++;
                continue;
            end
            ln = int'(stream[i+1]);
            if (ln > MAXL) begin
                m_err++;
                i += 2;
                continue;
            end
            total = ln + int'(stream[i+2+ln]);
            for (int k = 0; k < ln; k++) total += int'(stream[i+2+k]);
            if (total % 256 == 0) begin
                m_ok++;
                for (int k = 0; k < ln; k++) exp_q.push_back({(k == ln - 1), stream[i+2+k]});
            end else begin
                m_err++;
            end
            i += ln + 3;
        end
    endtask

    function automatic logic [7:0] junk();
        logic [7:0] v = 8'($urandom_range(0, 255));
        return (v == SYNC) ? 8'h5A : v;
    endfunction

    typedef struct packed {
        logic [7:0]       n;
        logic [19:0][7:0] b;
        logic [7:0]       exp_ok;
        logic [7:0]       exp_err;
        logic [7:0]       exp_nout;
        logic [7:0]       exp_tail;
    } vec_t;

    vec_t vecs [7];
    int   s_ok, s_err, s_ovr, s_got, nl;

    initial begin
        // 3+11+22+33 = 0x69 -> CHK 0x97
        vecs[0] = '{8'd6, 160'({8'h97, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5}), 8'd1, 8'd0, 8'd3, 8'h33};
        vecs[1] = '{8'd5, 160'({8'h00, 8'h20, 8'h10, 8'h02, 8'hA5}), 8'd0, 8'd1, 8'd0, 8'h00};
        vecs[2] = '{8'd2, 160'({8'h11, 8'hA5}), 8'd0, 8'd1, 8'd0, 8'h00};
        vecs[3] = '{8'd3, 160'({8'h00, 8'h00, 8'hA5}), 8'd1, 8'd0, 8'd0, 8'h00};
        vecs[4] = '{8'd5, 160'({8'h00, 8'hFF, 8'h01, 8'hA5, 8'h5A}), 8'd1, 8'd0, 8'd1, 8'hFF};
        // 2+A5+A5 = 0x4C -> CHK 0xB4
        vecs[5] = '{8'd5, 160'({8'hB4, 8'hA5, 8'hA5, 8'h02, 8'hA5}), 8'd1, 8'd0, 8'd2, 8'hA5};
        // 16 + (0+..+15) = 0x88 -> CHK 0x78
        vecs[6] = '{8'd19, 160'(0), 8'd1, 8'd0, 8'd16, 8'h0F};
        vecs[6].b[0] = SYNC;
        vecs[6].b[1] = 8'd16;
        for (int k = 0; k < 16; k++) vecs[6].b[2+k] = 8'(k);
        vecs[6].b[18] = 8'h78;

        rst = 1'b0;
        rx_ready = 1'b0;
        rx_word = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_data, out_valid, out_last, pkt_ok, pkt_err, overrun, busy}, 0);
        rst = 1'b1;
        @(negedge clk);

        // First-byte latency and back-to-back drain
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge clk);
        rx_word = 8'h97;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("lat_valid", out_valid, 1'b1);
        check("lat_pkt_ok", pkt_ok, 1'b1);
        check("lat_d0", out_data, 8'h11);
        @(negedge clk);
        check("ok_one_pulse", pkt_ok, 1'b0);
        check("lat_d1", {out_valid, out_last, out_data}, {2'b10, 8'h22});
        @(negedge clk);
        check("lat_d2_last", {out_valid, out_last, out_data}, {2'b11, 8'h33});
        @(negedge clk);
        check("lat_done", {out_valid, busy}, 2'b00);

        // Table-driven packets
        for (int v = 0; v < 7; v++) begin
            s_ok = mon_ok; s_err = mon_err; s_got = got_q.size();
            for (int k = 0; k < int'(vecs[v].n); k++) send_byte(vecs[v].b[k]);
            wait_idle(200);
            check($sformatf("vec%0d_ok", v), mon_ok - s_ok, vecs[v].exp_ok);
            check($sformatf("vec%0d_err", v), mon_err - s_err, vecs[v].exp_err);
            check($sformatf("vec%0d_nout", v), got_q.size() - s_got, vecs[v].exp_nout);
            if (vecs[v].exp_nout != 0) begin
                nl = 0;
                for (int k = s_got; k < got_q.size(); k++) nl += int'(got_q[k][8]);
                check($sformatf("vec%0d_tail", v), got_q[got_q.size()-1], {1'b1, vecs[v].exp_tail});
                check($sformatf("vec%0d_nlast", v), nl, 1);
            end
        end

        // Backpressure with an overrun byte: 2+AA+BB = 0x67 -> CHK 0x99
        rdy_mode = 0;
        s_ok = mon_ok; s_ovr = mon_ovr; s_got = got_q.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h99);
        repeat (20) @(negedge clk);
        check("bp_hold", {out_valid, out_last, out_data}, {2'b10, 8'hAA});
        send_byte(8'h42);
        repeat (2) @(negedge clk);
        check("bp_overrun", mon_ovr - s_ovr, 1);
        check("bp_busy", busy, 1'b1);
        rdy_mode = 1;
        wait_idle(100);
        check("bp_nout", got_q.size() - s_got, 2);
        if (got_q.size() - s_got == 2) begin
            check("bp_b0", got_q[s_got], {1'b0, 8'hAA});
            check("bp_b1", got_q[s_got+1], {1'b1, 8'hBB});
        end
        check("bp_ok", mon_ok - s_ok, 1);

        // Reset during the second payload byte
        s_ok = mon_ok; s_err = mon_err; s_got = got_q.size();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        @(negedge clk);
        rx_word = 8'h02;
        rx_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_outputs", {out_data, out_valid, out_last, pkt_ok, pkt_err, overrun, busy}, 0);
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'h04); send_byte(8'h7E); send_byte(8'h00);
        check("post_rst_idle", busy, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
        wait_idle(100);
        check("post_rst_ok", mon_ok - s_ok, 1);
        check("post_rst_err", mon_err - s_err, 0);
        check("post_rst_byte", got_q[got_q.size()-1], {1'b1, 8'h7E});

        // Randomized packets against the packet-level model
        rdy_mode = 2;
        stream.delete();
        s_ok = mon_ok; s_err = mon_err; s_got = got_q.size();
        for (int p = 0; p < 40; p++) begin
            int kind = $urandom_range(0, 9);
            int ln = $urandom_range(0, MAXL);
            int s;
            logic [7:0] pk [$];
            repeat ($urandom_range(0, 2)) send_byte(junk());
            if (kind == 9) begin
                send_byte(junk());
            end else if (kind == 8) begin
                send_byte(SYNC);
                send_byte(8'($urandom_range(MAXL + 1, 255)));
            end else begin
                s = ln;
                for (int k = 0; k < ln; k++) begin
                    pk.push_back(8'($urandom_range(0, 255)));
                    s += int'(pk[k]);
                end
                s = (256 - (s % 256)) % 256;
                if (kind >= 6) s = (s + $urandom_range(1, 255)) % 256;
                send_byte(SYNC);
                send_byte(8'(ln));
                foreach (pk[k]) send_byte(pk[k]);
                send_byte(8'(s));
            end
            wait_idle(600);
        end
        model_stream();
        check("rand_ok", mon_ok - s_ok, m_ok);
        check("rand_err", mon_err - s_err, m_err);
        check("rand_nbytes", got_q.size() - s_got, exp_q.size());
        for (int k = 0; k < exp_q.size() && s_got + k < got_q.size(); k++)
            check($sformatf("rand_byte%0d", k), got_q[s_got+k], exp_q[k]);

        check("ok_err_exclusive", mon_both, 0);
        check("stall_stability", mon_stab, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
